// File: rtl/axi4_stream_mul_responder_pkg.sv
// Shared definitions for the AXI4-Stream multiply link (responder and master
// wrapper): the frame state encoding and beat-count helpers.
package axi4_stream_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RX_A = 3'd1,
    RX_B = 3'd2,
    CALC = 3'd3,
    TX   = 3'd4
  } state_t;

  // Beats per operand.
  function automatic int nop_f(input int sz, input int dsz);
    return sz / dsz;
  endfunction

  // Beats per full-width product.
  function automatic int nres_f(input int sz, input int dsz);
    return (2 * sz) / dsz;
  endfunction

  // Counter width able to index n beats (never narrower than one bit).
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/axi4_stream_mul_responder_if.sv
// Stream bundle between the multiply master wrapper and the responder.
//   tdata/tvalid/tlast_to_slave, tready_to_slave : operand stream (master -> responder)
//   tdata/tvalid/tlast_to_master, tready_to_master : result stream (responder -> master)
//   busy, err : responder status; state : responder FSM state for observation
// Handshake: a beat transfers on a rising clk edge where valid and ready are
// both 1; the source holds data, valid and last stable until that edge, and
// ready never depends combinationally on valid.
interface axi4_stream_mul_if #(
  parameter int DSZ = 8
);
  import axi4_stream_pkg::*;

  logic [DSZ-1:0] tdata_to_slave;
  logic           tvalid_to_slave;
  logic           tlast_to_slave;
  logic           tready_to_slave;
  logic [DSZ-1:0] tdata_to_master;
  logic           tvalid_to_master;
  logic           tlast_to_master;
  logic           tready_to_master;
  logic           busy;
  logic           err;
  state_t         state;

  // Responder side.
  modport slave (
    input  tdata_to_slave, tvalid_to_slave, tlast_to_slave, tready_to_master,
    output tready_to_slave, tdata_to_master, tvalid_to_master, tlast_to_master,
    output busy, err, state
  );

  // Master wrapper side.
  modport master (
    output tdata_to_slave, tvalid_to_slave, tlast_to_slave, tready_to_master,
    input  tready_to_slave, tdata_to_master, tvalid_to_master, tlast_to_master,
    input  busy, err, state
  );

endinterface

// File: rtl/axi4_stream_beat_serializer.sv
// Parallel-load shift-out register: a W-bit word is loaded in one cycle and
// presented as W/DSZ beats, LSB-first, with tvalid/tready/tlast.
//   clk, _rst : clock, synchronous active-low reset
//   load, din : load a new word (only issued while idle)
//   tdata, tvalid, tlast, tready : outgoing beat stream
//   done : final beat handshakes this cycle
module axi4_stream_beat_serializer
  import axi4_stream_pkg::*;
#(
  parameter int W   = 64,
  parameter int DSZ = 8
) (
  input  logic           clk,
  input  logic           _rst,
  input  logic           load,
  input  logic [W-1:0]   din,
  output logic [DSZ-1:0] tdata,
  output logic           tvalid,
  output logic           tlast,
  input  logic           tready,
  output logic           done
);

  localparam int N  = W / DSZ;
  localparam int CW = cnt_w(N);

  logic [W-1:0]  sh;
  logic [CW-1:0] j;
  logic          valid;

  always_ff @(posedge clk) begin
    if (!_rst) begin
      sh    <= '0;
      j     <= '0;
      valid <= 1'b0;
    end else if (load) begin
      sh    <= din;
      j     <= '0;
      valid <= 1'b1;
    end else if (valid && tready) begin
      // The current beat always sits in the low DSZ bits.
      sh <= sh >> DSZ;
      if (j == CW'(N - 1)) begin
        j     <= '0;
        valid <= 1'b0;
      end else begin
        j <= j + 1'b1;
      end
    end
  end

  assign tdata  = sh[DSZ-1:0];
  assign tvalid = valid;
  assign tlast  = valid && (j == CW'(N - 1));
  assign done   = valid && tready && (j == CW'(N - 1));

endmodule

// File: rtl/axi4_stream_mul_responder.sv
// Multiply-link responder: receives operand a then operand b as LSB-first
// DSZ-bit beats, computes the full 2*SZ-bit unsigned product in one cycle and
// streams it back LSB-first. Framing errors pulse err for one cycle.
//   clk, _rst : clock, synchronous active-low reset
//   strm      : stream bundle (operand in, result out, busy/err/state status)
module axi4_stream_mul_responder
  import axi4_stream_pkg::*;
#(
  parameter int SZ  = 32,
  parameter int DSZ = 8
) (
  input  logic clk,
  input  logic _rst,
  axi4_stream_mul_if.slave strm
);

  localparam int NOP  = nop_f(SZ, DSZ);
  localparam int NRES = nres_f(SZ, DSZ);
  localparam int CW   = cnt_w(NRES);
  localparam int PW   = 2 * SZ;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [SZ-1:0] a, b;
  logic          busy, busy_n;
  logic          err, err_n;
  logic          wr_a, wr_b, load;
  logic          rdy, hs, drop, tx_done;
  logic [PW-1:0] prod;

  // Ready is a pure state decode.
  assign rdy = (state == RX_A) || (state == RX_B);
  assign hs  = rdy && strm.tvalid_to_slave;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    busy_n  = busy;
    err_n   = 1'b0;
    wr_a    = 1'b0;
    wr_b    = 1'b0;
    load    = 1'b0;
    drop    = 1'b0;
    case (state)
      IDLE: begin
        state_n = RX_A;
        cnt_n   = '0;
      end
      RX_A: begin
        if (hs) begin
          busy_n = 1'b1;
          if (strm.tlast_to_slave) begin
            drop = 1'b1;
          end else begin
            wr_a = 1'b1;
            if (cnt == CW'(NOP - 1)) begin
              state_n = RX_B;
              cnt_n   = '0;
            end else begin
              cnt_n = cnt + 1'b1;
            end
          end
        end
      end
      RX_B: begin
        if (hs) begin
          if (cnt == CW'(NOP - 1)) begin
            // Final b beat: processed either way, a missing tlast only flags.
            wr_b    = 1'b1;
            state_n = CALC;
            cnt_n   = '0;
            err_n   = !strm.tlast_to_slave;
          end else if (strm.tlast_to_slave) begin
            drop = 1'b1;
          end else begin
            wr_b  = 1'b1;
            cnt_n = cnt + 1'b1;
          end
        end
      end
      CALC: begin
        load    = 1'b1;
        state_n = TX;
      end
      TX: begin
        if (tx_done) begin
          state_n = RX_A;
          busy_n  = 1'b0;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
    // Early tlast abandons the frame and waits for a fresh operand a.
    if (drop) begin
      state_n = RX_A;
      cnt_n   = '0;
      err_n   = 1'b1;
      busy_n  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!_rst) begin
      state <= IDLE;
      cnt   <= '0;
      a     <= '0;
      b     <= '0;
      busy  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      busy  <= busy_n;
      err   <= err_n;
      if (wr_a) a[cnt*DSZ +: DSZ] <= strm.tdata_to_slave;
      if (wr_b) b[cnt*DSZ +: DSZ] <= strm.tdata_to_slave;
    end
  end

  assign prod = PW'(a) * PW'(b);

  axi4_stream_beat_serializer #(
    .W   (PW),
    .DSZ (DSZ)
  ) u_ser (
    .clk    (clk),
    ._rst   (_rst),
    .load   (load),
    .din    (prod),
    .tdata  (strm.tdata_to_master),
    .tvalid (strm.tvalid_to_master),
    .tlast  (strm.tlast_to_master),
    .tready (strm.tready_to_master),
    .done   (tx_done)
  );

  assign strm.tready_to_slave = rdy;
  assign strm.busy            = busy;
  assign strm.err             = err;
  assign strm.state           = state;

endmodule
